// File: rtl/turn_manager_pkg.sv
// Shared definitions for the paper-soccer turn sequencer.
//   state_t            : FSM state encoding (IDLE, ARM, RUN, DONE)
//   P0 / P1            : player identifiers
//   DEFAULT_MAX_MISSES : default consecutive-timeout forfeit limit
package turn_manager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int DEFAULT_MAX_MISSES = 3;

endpackage

// File: rtl/turn_manager_if.sv
// Signal bundle between the turn sequencer and its surroundings
// (board logic, move-timeout timer).
//   master : the environment side; drives game/move/timer-status inputs
//   slave  : the turn_manager side; drives timer control and game status
interface turn_manager_if #(
    parameter int MISS_W = 2
);
    logic              game_start;
    logic              first_player;
    logic              move_valid;
    logic              move_again;
    logic              game_over;
    logic              time_expire;
    logic              timer_start;
    logic              timer_rst;
    logic              current_player;
    logic              timeout_pulse;
    logic [MISS_W-1:0] miss_count0;
    logic [MISS_W-1:0] miss_count1;
    logic              forfeit;
    logic              loser;
    logic [7:0]        move_count;

    modport master (
        output game_start, first_player, move_valid, move_again,
               game_over, time_expire,
        input  timer_start, timer_rst, current_player, timeout_pulse,
               miss_count0, miss_count1, forfeit, loser, move_count
    );

    modport slave (
        input  game_start, first_player, move_valid, move_again,
               game_over, time_expire,
        output timer_start, timer_rst, current_player, timeout_pulse,
               miss_count0, miss_count1, forfeit, loser, move_count
    );

endinterface

// File: rtl/turn_manager_miss_tracker.sv
// Per-player consecutive-timeout counters, saturating at MAX_MISSES.
//   clk, rst    : clock, synchronous active-high reset
//   clear_all   : clear both counters (new game)
//   clr         : clear the counter of clr_player (player moved)
//   inc         : increment the counter of inc_player (player timed out)
//   count0/1    : current counts
//   limit_hit   : the pending increment for inc_player would reach MAX_MISSES
module miss_tracker
    import turn_manager_pkg::*;
#(
    parameter int MAX_MISSES = DEFAULT_MAX_MISSES,
    parameter int MISS_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_all,
    input  logic              clr,
    input  logic              clr_player,
    input  logic              inc,
    input  logic              inc_player,
    output logic [MISS_W-1:0] count0,
    output logic [MISS_W-1:0] count1,
    output logic              limit_hit
);

    localparam logic [MISS_W-1:0] MAX_CNT = MISS_W'(MAX_MISSES);

    logic [MISS_W-1:0] inc0;
    logic [MISS_W-1:0] inc1;

    // Saturating increment values, so a count never wraps past the limit.
    always_comb begin
        inc0 = (count0 == MAX_CNT) ? count0 : count0 + 1'b1;
        inc1 = (count1 == MAX_CNT) ? count1 : count1 + 1'b1;
        limit_hit = ((inc_player == P1) ? inc1 : inc0) == MAX_CNT;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            count0 <= '0;
            count1 <= '0;
        end else begin
            if (clr && clr_player == P0)
                count0 <= '0;
            else if (inc && inc_player == P0)
                count0 <= inc0;

            if (clr && clr_player == P1)
                count1 <= '0;
            else if (inc && inc_player == P1)
                count1 <= inc1;
        end
    end

endmodule

// File: rtl/turn_manager.sv
// Turn sequencer for the paper-soccer game core. Controls the move-timeout
// timer, tracks whose turn it is, counts moves and consecutive timeouts and
// declares a forfeit when a player reaches the miss limit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : turn_manager_if slave port (game/move inputs, timer_start,
//              timer_rst, current_player, timeout_pulse, miss counts,
//              forfeit, loser, move_count)
module turn_manager
    import turn_manager_pkg::*;
#(
    parameter int MAX_MISSES = DEFAULT_MAX_MISSES,
    parameter int MISS_W     = 2
) (
    input  logic           clk,
    input  logic           rst,
    turn_manager_if.slave  bus
);

    state_t     state, state_next;
    logic       player, player_next;
    logic [7:0] moves, moves_next;
    logic       forfeit_q, forfeit_next;
    logic       loser_q, loser_next;
    logic       pulse_q, pulse_next;

    logic       clear_all, clr, inc, limit_hit;

    miss_tracker #(
        .MAX_MISSES (MAX_MISSES),
        .MISS_W     (MISS_W)
    ) u_miss (
        .clk        (clk),
        .rst        (rst),
        .clear_all  (clear_all),
        .clr        (clr),
        .clr_player (player),
        .inc        (inc),
        .inc_player (player),
        .count0     (bus.miss_count0),
        .count1     (bus.miss_count1),
        .limit_hit  (limit_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            player    <= P0;
            moves     <= '0;
            forfeit_q <= 1'b0;
            loser_q   <= P0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_next;
            player    <= player_next;
            moves     <= moves_next;
            forfeit_q <= forfeit_next;
            loser_q   <= loser_next;
            pulse_q   <= pulse_next;
        end
    end

    always_comb begin
        state_next   = state;
        player_next  = player;
        moves_next   = moves;
        forfeit_next = forfeit_q;
        loser_next   = loser_q;
        pulse_next   = 1'b0;
        clear_all    = 1'b0;
        clr          = 1'b0;
        inc          = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (bus.game_start) begin
                    player_next  = bus.first_player;
                    moves_next   = '0;
                    forfeit_next = 1'b0;
                    loser_next   = P0;
                    clear_all    = 1'b1;
                    state_next   = ARM;
                end
            end
            ARM: begin
                state_next = bus.game_over ? DONE : RUN;
            end
            RUN: begin
                // game_over beats a move, and a move beats a timeout.
                if (bus.game_over) begin
                    state_next = DONE;
                end else if (bus.move_valid) begin
                    clr        = 1'b1;
                    moves_next = moves + 8'd1;
                    if (!bus.move_again)
                        player_next = ~player;
                    state_next = ARM;
                end else if (bus.time_expire) begin
                    inc        = 1'b1;
                    pulse_next = 1'b1;
                    if (limit_hit) begin
                        forfeit_next = 1'b1;
                        loser_next   = player;
                        state_next   = DONE;
                    end else begin
                        player_next = ~player;
                        state_next  = ARM;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.timer_rst      = (state != RUN);
    assign bus.timer_start    = (state == RUN);
    assign bus.current_player = player;
    assign bus.timeout_pulse  = pulse_q;
    assign bus.forfeit        = forfeit_q;
    assign bus.loser          = loser_q;
    assign bus.move_count     = moves;

endmodule
